// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, data width and the bit-period helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } txState_t;

    // Clocks per bit minus one; the bit counter counts down from this value to zero.
    function automatic int calcBitClk(input int clockFrequency, input int baudRate);
        return clockFrequency / baudRate - 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmitter; show-ahead read port, extra pointer bit separates full from empty.
// Push while full and pop while empty are ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clockIN,
    input  logic                      nTxResetIN,
    input  logic                      push,
    input  logic                      pop,
    input  logic [UART_DATA_BITS-1:0] wrData,
    output logic [UART_DATA_BITS-1:0] rdData,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]               wrPtr;
    logic [AW:0]               rdPtr;
    logic                      doPush;
    logic                      doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr[AW-1:0]];

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clockIN) begin
        if (!nTxResetIN) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; entries are only readable once the pointers mark them valid.
    always_ff @(posedge clockIN) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent as 8N1 frames, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 9600,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                      clockIN,
    input  logic                      nTxResetIN,
    input  logic [UART_DATA_BITS-1:0] txDataIN,
    input  logic                      txValidIN,
    output logic                      txReadyOUT,
    output logic                      txOUT,
    output logic                      txIdleOUT
);

    localparam int BIT_CLK = calcBitClk(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int CW      = $clog2(BIT_CLK + 1);
    localparam int IW      = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(BIT_CLK);
    localparam logic [CW-1:0] CNT_ONE    = 1;
    localparam logic [IW-1:0] LAST_BIT   = IW'(UART_DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE    = 1;

    txState_t                  state,    stateNext;
    logic [CW-1:0]             bitCnt,   bitCntNext;
    logic [IW-1:0]             bitIdx,   bitIdxNext;
    logic [UART_DATA_BITS-1:0] shiftReg, shiftNext;
    logic                      txReg,    txNext;
    logic                      fifoPop;
    logic                      fifoFull;
    logic                      fifoEmpty;
    logic [UART_DATA_BITS-1:0] fifoData;
`ifdef UART_TX_PARITY_EN
    logic                      parityReg, parityNext;
`endif

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) txFifo (
        .clockIN    (clockIN),
        .nTxResetIN (nTxResetIN),
        .push       (txValidIN),
        .pop        (fifoPop),
        .wrData     (txDataIN),
        .rdData     (fifoData),
        .full       (fifoFull),
        .empty      (fifoEmpty)
    );

    assign txOUT      = txReg;
    assign txReadyOUT = !fifoFull;
    assign txIdleOUT  = (state == IDLE) && fifoEmpty;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt - CNT_ONE;
        bitIdxNext = bitIdx;
        shiftNext  = shiftReg;
        txNext     = txReg;
        fifoPop    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parityNext = parityReg;
`endif
        unique case (state)
            IDLE: begin
                txNext     = 1'b1;
                bitCntNext = bitCnt;
                if (!fifoEmpty) begin
                    fifoPop    = 1'b1;
                    shiftNext  = fifoData;
                    stateNext  = START;
                    txNext     = 1'b0;
                    bitCntNext = CNT_RELOAD;
`ifdef UART_TX_PARITY_EN
                    parityNext = ^fifoData;
`endif
                end
            end
            START: begin
                if (bitCnt == '0) begin
                    stateNext  = DATA;
                    txNext     = shiftReg[0];
                    bitIdxNext = '0;
                    bitCntNext = CNT_RELOAD;
                end
            end
            DATA: begin
                if (bitCnt == '0) begin
                    shiftNext  = shiftReg >> 1;
                    bitCntNext = CNT_RELOAD;
                    if (bitIdx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        stateNext = PARITY;
                        txNext    = parityReg;
`else
                        stateNext = STOP;
                        txNext    = 1'b1;
`endif
                    end else begin
                        bitIdxNext = bitIdx + IDX_ONE;
                        txNext     = shiftReg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitCnt == '0) begin
                    stateNext  = STOP;
                    txNext     = 1'b1;
                    bitCntNext = CNT_RELOAD;
                end
            end
`endif
            STOP: begin
                txNext = 1'b1;
                if (bitCnt == '0) begin
                    bitCntNext = CNT_RELOAD;
                    // Queued bytes chain straight into the next start bit.
                    if (!fifoEmpty) begin
                        fifoPop   = 1'b1;
                        shiftNext = fifoData;
                        stateNext = START;
                        txNext    = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parityNext = ^fifoData;
`endif
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext  = IDLE;
                txNext     = 1'b1;
                bitCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clockIN) begin
        if (!nTxResetIN) begin
            state    <= IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            txReg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parityReg <= 1'b0;
`endif
        end else begin
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
            txReg    <= txNext;
`ifdef UART_TX_PARITY_EN
            parityReg <= parityNext;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx at 10 clocks per bit: FIFO/frame-timing model feeding a byte scoreboard,
// a line monitor checking every clock of every frame, a handshake table, and reset/parity corner cases.
module tb_uart_tx;

    localparam int CLK_F = 1_000_000;
    localparam int BAUD  = 100_000;
    localparam int DEPTH = 4;
    localparam int BIT   = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * BIT;

    logic       clockIN = 1'b0;
    logic       nTxResetIN;
    logic [7:0] txDataIN;
    logic       txValidIN;
    logic       txReadyOUT;
    logic       txOUT;
    logic       txIdleOUT;

    int nChecks = 0;
    int nErrors = 0;
    bit chkEn = 0;

    // Reference model: FIFO occupancy and frame timer, plus expected-byte scoreboard.
    int         mCount = 0;
    int         mTimer = 0;
    bit         mBusy  = 0;
    logic [7:0] sbQ [$];

    // Line monitor state.
    bit          monActive = 0;
    int          monBit;
    int          monClk;
    int          frameErr;
    logic [10:0] monExp;
    logic [7:0]  monByte;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       expReady;
        logic       expIdle;
    } vec_t;
    vec_t vecs [8];

    uart_tx #(
        .CLOCK_FREQUENCY (CLK_F),
        .BAUD_RATE       (BAUD),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clockIN    (clockIN),
        .nTxResetIN (nTxResetIN),
        .txDataIN   (txDataIN),
        .txValidIN  (txValidIN),
        .txReadyOUT (txReadyOUT),
        .txOUT      (txOUT),
        .txIdleOUT  (txIdleOUT)
    );

    always #5 clockIN = ~clockIN;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        @(negedge clockIN);
        #1 txDataIN = b;
        txValidIN = 1'b1;
        @(negedge clockIN);
        #1 txValidIN = 1'b0;
    endtask

    task automatic waitIdle(input int maxCyc);
        int n = 0;
        while (txIdleOUT !== 1'b1 && n < maxCyc) begin
            @(negedge clockIN);
            n++;
        end
        check("wait_idle_in_time", 32'(n < maxCyc), 1);
    endtask

    always @(posedge clockIN) begin
        bit doPush;
        bit doPop;
        if (!nTxResetIN) begin
            mCount = 0;
            mBusy  = 0;
            mTimer = 0;
            sbQ.delete();
        end else begin
            doPop  = 0;
            doPush = txValidIN && (mCount < DEPTH);
            if (mBusy) begin
                mTimer--;
                if (mTimer == 0) begin
                    if (mCount > 0) begin
                        doPop  = 1;
                        mTimer = FL;
                    end else begin
                        mBusy = 0;
                    end
                end
            end else if (mCount > 0) begin
                doPop  = 1;
                mBusy  = 1;
                mTimer = FL;
            end
            if (doPush) sbQ.push_back(txDataIN);
            mCount = mCount + int'(doPush) - int'(doPop);
        end
    end

    always @(negedge clockIN) begin
        if (!nTxResetIN) begin
            monActive = 0;
        end else begin
            if (chkEn) begin
                check("ready", 32'(txReadyOUT), 32'(mCount < DEPTH));
                check("idle", 32'(txIdleOUT), 32'(!mBusy && mCount == 0));
                if (!mBusy) check("line_high_when_idle", 32'(txOUT), 1);
            end
            if (!monActive && txOUT === 1'b0) begin
                check("frame_expected", 32'(sbQ.size() != 0), 1);
                if (sbQ.size() != 0) begin
                    monByte   = sbQ.pop_front();
                    monExp    = '1;
                    monExp[0] = 1'b0;
                    monExp[8:1] = monByte;
`ifdef UART_TX_PARITY_EN
                    monExp[9] = ^monByte;
`endif
                    monActive = 1;
                    monBit    = 0;
                    monClk    = 0;
                    frameErr  = 0;
                end
            end
            if (monActive) begin
                if (txOUT !== monExp[monBit]) frameErr++;
                monClk++;
                if (monClk == BIT) begin
                    monClk = 0;
                    monBit++;
                    if (monBit == NBITS) begin
                        check($sformatf("frame_%02h_bit_errors", monByte), frameErr, 0);
                        monActive = 0;
                    end
                end
            end
        end
    end

    initial begin
        int accepted;
        int cyc;

        vecs[0] = '{1'b1, 8'h00, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h81, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'h99, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h77, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0};

        nTxResetIN = 1'b0;
        txValidIN  = 1'b0;
        txDataIN   = '0;
        repeat (3) @(negedge clockIN);
        check("reset_tx", 32'(txOUT), 1);
        check("reset_ready", 32'(txReadyOUT), 1);
        check("reset_idle", 32'(txIdleOUT), 1);
        #1 nTxResetIN = 1'b1;
        chkEn = 1;

        // Single byte: start bit two clocks after the accepting edge, idle again after one frame.
        pushByte(8'h55);
        check("start_not_yet", 32'(txOUT), 1);
        @(negedge clockIN);
        check("start_edge", 32'(txOUT), 0);
        repeat (FL - 1) @(negedge clockIN);
        check("idle_during_last_stop_clock", 32'(txIdleOUT), 0);
        @(negedge clockIN);
        check("idle_after_frame", 32'(txIdleOUT), 1);

        // FIFO fill on consecutive cycles, then valid held while full.
        for (int i = 0; i < 8; i++) begin
            @(negedge clockIN);
            check($sformatf("vec%0d_ready", i), 32'(txReadyOUT), 32'(vecs[i].expReady));
            check($sformatf("vec%0d_idle", i), 32'(txIdleOUT), 32'(vecs[i].expIdle));
            #1 txValidIN = vecs[i].valid;
            txDataIN = vecs[i].data;
        end
        for (int i = 0; i < 250; i++) begin
            @(negedge clockIN);
            #1 txValidIN = 1'b1;
            txDataIN = 8'(i + 16);
        end
        @(negedge clockIN);
        #1 txValidIN = 1'b0;
        waitIdle(12 * FL);

        // Reset during data bit 3 with bytes still queued.
        pushByte(8'hF0);
        pushByte(8'h11);
        pushByte(8'h22);
        repeat (40) @(negedge clockIN);
        #1 nTxResetIN = 1'b0;
        @(negedge clockIN);
        check("mid_reset_tx", 32'(txOUT), 1);
        check("mid_reset_ready", 32'(txReadyOUT), 1);
        check("mid_reset_idle", 32'(txIdleOUT), 1);
        #1 nTxResetIN = 1'b1;
        pushByte(8'h42);
        waitIdle(2 * FL);
        check("after_reset_sb_empty", sbQ.size(), 0);

`ifdef UART_TX_PARITY_EN
        pushByte(8'h07);
        repeat (96) @(negedge clockIN);
        check("parity_07", 32'(txOUT), 1);
        waitIdle(2 * FL);
        pushByte(8'h03);
        repeat (96) @(negedge clockIN);
        check("parity_03", 32'(txOUT), 0);
        waitIdle(2 * FL);
`endif

        // 256 random bytes streamed through a continuously offered handshake.
        accepted = 0;
        cyc = 0;
        while (accepted < 256 && cyc < 40000) begin
            @(negedge clockIN);
            #1 txDataIN = 8'($urandom);
            txValidIN = 1'b1;
            if (mCount < DEPTH) accepted++;
            cyc++;
        end
        @(negedge clockIN);
        #1 txValidIN = 1'b0;
        check("random_accepted", accepted, 256);
        waitIdle(8 * FL);
        check("sb_drained", sbQ.size(), 0);
        check("monitor_done", 32'(monActive), 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the board's UART receiver: it sends 8N1 frames (optional even parity) on a single TX line at a fixed baud rate. Bytes enter through a valid/ready handshake into a small FIFO, so the display and echo logic can queue several characters without stalling. It sits between the character/command logic and the board's TX pin.

## Interface
- `CLOCK_FREQUENCY`, 50_000_000, system clock in Hz
- `BAUD_RATE`, 9600, line rate in bit/s
- `FIFO_DEPTH`, 4, byte FIFO entries; power of two, ≥2
- `clockIN` input 1: the single system clock; all logic on its rising edge
- `nTxResetIN` input 1: reset, synchronous, active-low
- `txDataIN` input 8: byte to send
- `txValidIN` input 1: `txDataIN` is valid this cycle
- `txReadyOUT` output 1: FIFO can accept a byte (= FIFO not full)
- `txOUT` output 1: serial line, idle high
- `txIdleOUT` output 1: FSM in IDLE and FIFO empty

## Operation
- Bit period constant: `BIT_CLK = CLOCK_FREQUENCY/BAUD_RATE - 1`. The down-counter is `$clog2(BIT_CLK+1)` bits wide, and each bit lasts exactly `BIT_CLK+1` clocks.
- **Push:** when `txValidIN & txReadyOUT` are both high at an edge, write `txDataIN` into the FIFO.
  - Valid while full is ignored: no write, no error.
  - Push and pop in the same cycle are both performed and the count is unchanged. This is allowed when full: the pop frees the entry, but `txReadyOUT` is low that cycle, so no push happens.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP.
  - **IDLE:** `txOUT=1`. If the FIFO is non-empty at an edge: pop into an 8-bit shift register, go to START, drive `txOUT=0`, load counter with BIT_CLK.
  - **START:** when counter==0, go to DATA and drive shift[0], with bit index 0.
  - **DATA:** when counter==0, shift right. After bit index 7, go to PARITY (macro) or STOP; otherwise drive the next bit. Bits go LSB first.
  - **PARITY:** drive XOR of the 8 data bits (even parity). When counter==0, go to STOP.
  - **STOP:** `txOUT=1`. When counter==0:
    - FIFO non-empty: pop and go directly to START, with no idle gap.
    - FIFO empty: go to IDLE.
- The counter reloads with BIT_CLK on every state or bit transition and otherwise decrements.
- `txOUT` is a registered output with no combinational path from inputs.

## Timing
- **Reset values:** `txOUT=1`, `txReadyOUT=1`, `txIdleOUT=1`, FIFO empty, FSM IDLE, counter 0.
- **Reset mid-frame:** the frame is aborted, the FIFO is flushed, and `txOUT` returns high on the next clock. A truncated frame is acceptable.
- **Latency:**
  - Push at edge N into an empty FIFO with FSM in IDLE: the FIFO becomes non-empty after edge N, the pop happens at edge N+1, and `txOUT` falls after edge N+1.
  - Start-bit falling edge is therefore 2 clocks after the accepting edge.
- **Frame length:** 10·(BIT_CLK+1) clocks, or 11·(BIT_CLK+1) with parity.
- Back-to-back frames are contiguous: the STOP of one frame is followed directly by the START of the next.
- `txReadyOUT` is combinational from the FIFO count. It rises the cycle after a pop frees a full FIFO.
- `txIdleOUT` falls the cycle after the first accepted push. It rises the cycle after the final STOP completes with the FIFO empty.

## Configuration
- **`UART_TX_PARITY_EN` defined:** the PARITY state is compiled in, giving the frame start + 8 data + even parity + stop, 11 bits.
- **Undefined:** no PARITY state or parity logic; 8N1 frames of 10 bits.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - `UART_DATA_BITS=8`.
  - Shared `BIT_CLK` computation helper function, reused by the receiver.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with parameter `FIFO_DEPTH` and ports push, pop, data in/out, full, empty.
  - Pointer wrap uses `$clog2(FIFO_DEPTH)`-bit pointers plus an extra bit for the full/empty distinction.

## Test plan
Bench parameters: `CLOCK_FREQUENCY=1_000_000`, `BAUD_RATE=100_000`, which gives BIT_CLK=9 and 10 clocks/bit.
- **Single byte:** push 0x55 → `txOUT` shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data), each level exactly 10 clocks. Start edge is 2 clocks after the push. `txIdleOUT` is high again after 100 clocks.
- **FIFO fill:** push 0x00, 0xFF, 0xA5, 0x3C, 0x81 on consecutive cycles.
  - The first pops immediately, so five pushes are accepted only if the pop occurs before the fifth. The check is that `txReadyOUT` deasserts exactly when 4 entries are held.
  - Frames are decoded in push order with no idle gaps.
- **Push while full:** hold `txValidIN` high with changing data while full → only bytes accepted under `txReadyOUT` appear on the line.
- **Reset mid-frame:** assert `nTxResetIN` low for 1 clock during DATA bit 3 → `txOUT=1` the next cycle, FIFO empty, `txReadyOUT=1`; a subsequent push of 0x42 transmits correctly.
- **Parity (macro defined):** push 0x07 → parity bit 1, frame 110 clocks. Push 0x03 → parity bit 0.
- **Bit-time check:** a bench-side monitor samples mid-bit and compares against a reference UART model for 256 random bytes; zero mismatches are required.
